// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter and its
// round-robin priority encoder.
package fifo_wr_arb_pkg;

    localparam int N_REQ_MAX = 8;
    localparam int PTR_W     = $clog2(N_REQ_MAX);

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Index of the set bit in a one-hot vector; zero when no bit is set.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ_MAX-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = {PTR_W{1'b0}};
        for (int i = 0; i < N_REQ_MAX; i++) begin
            if (oh[i]) begin
                idx = PTR_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_prio_enc.sv
// Combinational round-robin priority encoder: first active request at or
// above the start pointer, wrapping around; reusable by the read-side scheduler.
module rr_prio_enc
    import fifo_wr_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] start,
    output logic [N-1:0]     gnt,
    output logic             any
);

    int  pos_s;
    logic found_s;

    // Scan N positions beginning at start, keeping only the first hit.
    always_comb begin
        gnt     = {N{1'b0}};
        found_s = 1'b0;
        pos_s   = 0;
        any     = |req;
        for (int k = 0; k < N; k++) begin
            pos_s = (int'(start) + k) % N;
            if (!found_s && req[pos_s]) begin
                gnt[pos_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-locked round-robin arbiter for the single write port of the MAC's
// async FIFO; per-beat full backpressure with a zero-latency datapath.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    wclk,
    input  logic                    wr_srstn,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    fifo_full,
    output logic                    fifo_wr_en,
    output logic [DATA_W-1:0]       fifo_wr_data,
    output logic                    fifo_wr_last,
    output logic [N_REQ-1:0]        grant,
    output logic [CNT_W-1:0]        frames_done
);

    arb_state_e             state_r, next_state_s;
    logic [PTR_W-1:0]       rr_ptr_r;
    logic [N_REQ-1:0]       grant_r;
    logic [CNT_W-1:0]       frames_done_r;

    logic [N_REQ-1:0]       enc_gnt_s;
    logic                   enc_any_s;
    logic [N_REQ_MAX-1:0]   grant_ext_s;
    logic [PTR_W-1:0]       owner_idx_s;
    logic [PTR_W-1:0]       next_ptr_s;
    logic                   xfer_s;
    logic                   owner_last_s;
    logic                   frame_end_s;

    rr_prio_enc #(.N(N_REQ)) u_enc (
        .req   (req_valid),
        .start (rr_ptr_r),
        .gnt   (enc_gnt_s),
        .any   (enc_any_s)
    );

    // Owner index and the pointer to resume the search after this owner.
    always_comb begin
        grant_ext_s            = {N_REQ_MAX{1'b0}};
        grant_ext_s[N_REQ-1:0] = grant_r;
        owner_idx_s            = onehot_to_idx(grant_ext_s);
        if (owner_idx_s == PTR_W'(N_REQ - 1)) begin
            next_ptr_s = {PTR_W{1'b0}};
        end else begin
            next_ptr_s = owner_idx_s + {{(PTR_W-1){1'b0}}, 1'b1};
        end
    end

    // Beat datapath and next-state logic; outputs stay zero while idle.
    always_comb begin
        next_state_s = state_r;
        req_ready    = {N_REQ{1'b0}};
        xfer_s       = 1'b0;
        owner_last_s = 1'b0;
        frame_end_s  = 1'b0;
        fifo_wr_data = {DATA_W{1'b0}};
        case (state_r)
            ARB_IDLE: begin
                if (enc_any_s) begin
                    next_state_s = ARB_LOCKED;
                end else begin
                    next_state_s = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                req_ready    = fifo_full ? {N_REQ{1'b0}} : grant_r;
                xfer_s       = |(req_valid & grant_r) && !fifo_full;
                owner_last_s = |(req_last & grant_r);
                frame_end_s  = xfer_s && owner_last_s;
                for (int i = 0; i < N_REQ; i++) begin
                    if (grant_r[i]) begin
                        fifo_wr_data = req_data[i*DATA_W +: DATA_W];
                    end else begin
                        fifo_wr_data = fifo_wr_data;
                    end
                end
                if (frame_end_s) begin
                    next_state_s = ARB_IDLE;
                end else begin
                    next_state_s = ARB_LOCKED;
                end
            end
            default: begin
                next_state_s = ARB_IDLE;
            end
        endcase
        fifo_wr_en   = xfer_s;
        fifo_wr_last = frame_end_s;
    end

    // State, grant, round-robin pointer and frame counter; reset wins over a beat.
    always_ff @(posedge wclk) begin
        if (!wr_srstn) begin
            state_r       <= ARB_IDLE;
            rr_ptr_r      <= {PTR_W{1'b0}};
            grant_r       <= {N_REQ{1'b0}};
            frames_done_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            case (state_r)
                ARB_IDLE: begin
                    if (enc_any_s) begin
                        grant_r <= enc_gnt_s;
                    end else begin
                        grant_r <= {N_REQ{1'b0}};
                    end
                end
                ARB_LOCKED: begin
                    if (frame_end_s) begin
                        grant_r       <= {N_REQ{1'b0}};
                        rr_ptr_r      <= next_ptr_s;
                        frames_done_r <= frames_done_r + CNT_W'(1);
                    end else begin
                        grant_r <= grant_r;
                    end
                end
                default: begin
                    grant_r <= {N_REQ{1'b0}};
                end
            endcase
        end
    end

    assign grant       = grant_r;
    assign frames_done = frames_done_r;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed, table-driven bench for fifo_wr_arbiter; a second instance with a
// 4-bit frame counter shares all inputs to exercise counter wrap.
module tb_fifo_wr_arbiter;

    logic        wclk;
    logic        wr_srstn;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic        fifo_full;

    logic [3:0]  req_ready,  req_ready4;
    logic        fifo_wr_en, fifo_wr_en4;
    logic [7:0]  fifo_wr_data, fifo_wr_data4;
    logic        fifo_wr_last, fifo_wr_last4;
    logic [3:0]  grant, grant4;
    logic [15:0] frames_done;
    logic [3:0]  frames_done4;

    int compared   = 0;
    int mismatched = 0;
    int wr_cnt     = 0;
    int last_cnt   = 0;

    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(8), .CNT_W(16)) dut (
        .wclk(wclk), .wr_srstn(wr_srstn), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .fifo_wr_last(fifo_wr_last),
        .grant(grant), .frames_done(frames_done)
    );

    fifo_wr_arbiter #(.N_REQ(4), .DATA_W(8), .CNT_W(4)) dut4 (
        .wclk(wclk), .wr_srstn(wr_srstn), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready4), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en4), .fifo_wr_data(fifo_wr_data4), .fifo_wr_last(fifo_wr_last4),
        .grant(grant4), .frames_done(frames_done4)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  l;
        logic        f;
        logic [3:0]  e_ready;
        logic        e_en;
        logic [7:0]  e_data;
        logic        e_last;
        logic [3:0]  e_grant;
        logic [15:0] e_frames;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs at the falling edge, then clock.
    task automatic step(input logic [3:0] v, input logic [31:0] d, input logic [3:0] l,
                        input logic f, input logic [3:0] e_ready, input logic e_en,
                        input logic [7:0] e_data, input logic e_last, input logic [3:0] e_grant,
                        input logic [15:0] e_frames);
        req_valid = v;
        req_data  = d;
        req_last  = l;
        fifo_full = f;
        @(negedge wclk);
        chk("req_ready",   {28'd0, req_ready},    {28'd0, e_ready});
        chk("fifo_wr_en",  {31'd0, fifo_wr_en},   {31'd0, e_en});
        chk("fifo_wr_data",{24'd0, fifo_wr_data}, {24'd0, e_data});
        chk("fifo_wr_last",{31'd0, fifo_wr_last}, {31'd0, e_last});
        chk("grant",       {28'd0, grant},        {28'd0, e_grant});
        chk("frames_done", {16'd0, frames_done},  {16'd0, e_frames});
        chk("frames_done4",{28'd0, frames_done4}, {28'd0, e_frames[3:0]});
        if (fifo_wr_en)   wr_cnt++;
        if (fifo_wr_last) last_cnt++;
        @(posedge wclk);
        #1;
    endtask

    task automatic do_reset();
        wr_srstn  = 1'b0;
        req_valid = 4'd0;
        req_data  = 32'd0;
        req_last  = 4'd0;
        fifo_full = 1'b0;
        @(posedge wclk);
        #1;
        wr_srstn = 1'b1;
    endtask

    function automatic logic [31:0] at(input int idx, input logic [7:0] b);
        logic [31:0] w;
        w = {24'd0, b};
        return w << (idx * 8);
    endfunction

    initial begin
        wclk      = 1'b0;
        wr_srstn  = 1'b0;
        req_valid = 4'd0;
        req_data  = 32'd0;
        req_last  = 4'd0;
        fifo_full = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        wr_srstn = 1'b1;

        // Reset state, then two frames: requester 0 (3 beats) and requester 2 (1 beat).
        //         v        d                             l        f     rdy      en    data    lst   gnt      frames
        tbl[0] = '{4'b0101, 32'h00C1_00A0,                4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd0};
        tbl[1] = '{4'b0101, 32'h00C1_00A1,                4'b0000, 1'b0, 4'b0001, 1'b1, 8'hA1, 1'b0, 4'b0001, 16'd0};
        tbl[2] = '{4'b0101, 32'h00C1_00A2,                4'b0000, 1'b0, 4'b0001, 1'b1, 8'hA2, 1'b0, 4'b0001, 16'd0};
        tbl[3] = '{4'b0101, 32'h00C1_00A3,                4'b0001, 1'b0, 4'b0001, 1'b1, 8'hA3, 1'b1, 4'b0001, 16'd0};
        tbl[4] = '{4'b0100, 32'h00C1_0000,                4'b0100, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd1};
        tbl[5] = '{4'b0100, 32'h00C1_0000,                4'b0100, 1'b0, 4'b0100, 1'b1, 8'hC1, 1'b1, 4'b0100, 16'd1};
        tbl[6] = '{4'b0000, 32'h0000_0000,                4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd2};
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].f, tbl[i].e_ready, tbl[i].e_en,
                 tbl[i].e_data, tbl[i].e_last, tbl[i].e_grant, tbl[i].e_frames);
        end

        // All four requesters stream single-beat frames: grants 0,1,2,3,0,... with bubbles.
        do_reset();
        for (int c = 0; c < 16; c++) begin
            if (c % 2 == 0) begin
                step(4'b1111, 32'h3322_1100, 4'b1111, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0,
                     4'b0000, 16'(c / 2));
            end else begin
                step(4'b1111, 32'h3322_1100, 4'b1111, 1'b0, 4'(1 << ((c / 2) % 4)), 1'b1,
                     8'(8'h11 * ((c / 2) % 4)), 1'b1, 4'(1 << ((c / 2) % 4)), 16'(c / 2));
            end
        end
        step(4'b0000, 32'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd8);

        // Requester 1, 5-beat frame with two full cycles before beat 2.
        do_reset();
        wr_cnt   = 0;
        last_cnt = 0;
        step(4'b0010, at(1, 8'h51), 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd0);
        step(4'b0010, at(1, 8'h51), 4'b0000, 1'b0, 4'b0010, 1'b1, 8'h51, 1'b0, 4'b0010, 16'd0);
        step(4'b0010, at(1, 8'h52), 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h52, 1'b0, 4'b0010, 16'd0);
        step(4'b0010, at(1, 8'h52), 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h52, 1'b0, 4'b0010, 16'd0);
        step(4'b0010, at(1, 8'h52), 4'b0000, 1'b0, 4'b0010, 1'b1, 8'h52, 1'b0, 4'b0010, 16'd0);
        step(4'b0010, at(1, 8'h53), 4'b0000, 1'b0, 4'b0010, 1'b1, 8'h53, 1'b0, 4'b0010, 16'd0);
        step(4'b0010, at(1, 8'h54), 4'b0000, 1'b0, 4'b0010, 1'b1, 8'h54, 1'b0, 4'b0010, 16'd0);
        step(4'b0010, at(1, 8'h55), 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h55, 1'b1, 4'b0010, 16'd0);
        step(4'b0000, 32'd0,        4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd1);
        chk("write_count", 32'(wr_cnt), 32'd5);
        chk("last_count",  32'(last_cnt), 32'd1);

        // Owner 0 drops valid for 4 cycles while requester 2 waits.
        do_reset();
        step(4'b0101, 32'h00C0_00B0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd0);
        step(4'b0101, 32'h00C0_00B1, 4'b0000, 1'b0, 4'b0001, 1'b1, 8'hB1, 1'b0, 4'b0001, 16'd0);
        for (int c = 0; c < 4; c++) begin
            step(4'b0100, 32'h00C0_00EE, 4'b0000, 1'b0, 4'b0001, 1'b0, 8'hEE, 1'b0, 4'b0001, 16'd0);
        end
        step(4'b0101, 32'h00C0_00B2, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'hB2, 1'b1, 4'b0001, 16'd0);
        step(4'b0100, 32'h00C0_0000, 4'b0100, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd1);
        step(4'b0100, 32'h00C0_0000, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'hC0, 1'b1, 4'b0100, 16'd1);
        step(4'b0000, 32'd0,         4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd2);

        // Reset on the 2nd beat of requester 1's frame; search restarts at requester 0.
        do_reset();
        step(4'b0001, at(0, 8'h01), 4'b0001, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd0);
        step(4'b0001, at(0, 8'h01), 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h01, 1'b1, 4'b0001, 16'd0);
        step(4'b0010, at(1, 8'h61), 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd1);
        step(4'b0010, at(1, 8'h61), 4'b0000, 1'b0, 4'b0010, 1'b1, 8'h61, 1'b0, 4'b0010, 16'd1);
        wr_srstn = 1'b0;
        step(4'b0010, at(1, 8'h62), 4'b0000, 1'b0, 4'b0010, 1'b1, 8'h62, 1'b0, 4'b0010, 16'd1);
        wr_srstn = 1'b1;
        step(4'b0011, 32'h0000_6301, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd0);
        step(4'b0011, 32'h0000_6301, 4'b0000, 1'b0, 4'b0001, 1'b1, 8'h01, 1'b0, 4'b0001, 16'd0);

        // 17 single-beat frames: the 4-bit counter wraps to 1.
        do_reset();
        for (int c = 0; c < 34; c++) begin
            if (c % 2 == 0) begin
                step(4'b0001, at(0, 8'h7F), 4'b0001, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0,
                     4'b0000, 16'(c / 2));
            end else begin
                step(4'b0001, at(0, 8'h7F), 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h7F, 1'b1,
                     4'b0001, 16'(c / 2));
            end
        end
        step(4'b0000, 32'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 4'b0000, 16'd17);
        chk("frames_done4_wrap", {28'd0, frames_done4}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
